ttt_game_ctrl: RTL and testbench
================================

TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1000, range 1..65535: cycles a player has in WAIT_MOVE before forfeiting.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 new_game  in  1  start/restart request, sampled every cycle.
REQ-005 move_valid  in  1  move offered by the current player.
REQ-006 move_cell  in  4  cell index 0..8, row-major; 9..15 illegal.
REQ-007 move_ready  out  1  high only in WAIT_MOVE.
REQ-008 win_x, win_o, full, error  in  1 each  evaluator flags, combinational from x_board/o_board.
REQ-009 x_board, o_board  out  9 each  registered occupancy, bit n = cell n; feeds the evaluator.
REQ-010 turn  out  1  0 = X to move, 1 = O to move.
REQ-011 move_count  out  4  accepted moves in the current game, 0..9.
REQ-012 move_ack, move_rej  out  1 each  one-cycle pulses, registered.
REQ-013 game_over  out  1  high in OVER.
REQ-014 result  out  2  00 none/fault, 01 X wins, 10 O wins, 11 draw; valid while game_over.
REQ-015 fault  out  1  high in OVER when the game ended on evaluator error.

Function
REQ-016 FSM states IDLE, WAIT_MOVE, EVAL, OVER; encoding free.
REQ-017 IDLE: move_ready=0; new_game=1 -> WAIT_MOVE next cycle.
REQ-018 new_game=1 in any state: next cycle boards=0, turn=0, move_count=0, timer=0, result=00, fault=0, state WAIT_MOVE; a same-cycle move is dropped, with no ack and no rej.
REQ-019 WAIT_MOVE, handshake when move_valid & move_ready:
  - move_cell>8, or cell set in x_board|o_board -> move_rej=1 next cycle; board and turn unchanged; timer keeps counting.
  - otherwise -> set bit move_cell in the board of turn; move_count+1; move_ack=1; state EVAL; all next cycle.
REQ-020 At most one move accepted per WAIT_MOVE visit; move_valid is ignored outside WAIT_MOVE.
REQ-021 Timer: in WAIT_MOVE without an accepted move, the timer increments each cycle.
  - After TIMEOUT cycles, the next cycle enters OVER with result = opponent of turn (turn 0 -> 10, turn 1 -> 01).
  - An accepted move on the same cycle as expiry takes priority over the forfeit.
REQ-022 EVAL, one cycle, flags sampled against the updated boards; priority error > win_x > win_o > full:
  - error -> OVER, result 00, fault 1.
  - win_x -> OVER, result 01.
  - win_o -> OVER, result 10.
  - full -> OVER, result 11.
  - none -> toggle turn, clear timer, WAIT_MOVE.
REQ-023 OVER: boards, result, turn and move_count hold; move_ready=0; only new_game or reset leaves OVER.
REQ-024 move_ack and move_rej are never high in the same cycle, and each is low in any cycle not directly following a handshake.
REQ-025 move_count saturates at 9; a tenth accept is unreachable because full ends the game.

Reset
REQ-026 rst_n=0 at a rising edge: state IDLE; x_board=o_board=0; turn=0; move_count=0; timer=0; move_ack=move_rej=0; game_over=0; result=00; fault=0.
REQ-027 Reset overrides new_game and any move in the same cycle, including mid-game and in OVER.

Verification
REQ-028 Reset, new_game pulse, X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> move_ack after each move; result 01 and game_over=1 two cycles after the last handshake; x_board=0x007, o_board=0x018.
REQ-029 X plays 4, then O offers cell 4, then O offers cell 12 -> two move_rej pulses; o_board=0, turn=1; O then plays 0 -> move_ack.
REQ-030 Full-board sequence X4,O0,X2,O6,X3,O5,X8,O1,X7 with no line, evaluator full=1 after the 9th move -> result 11, move_count=9.
REQ-031 TIMEOUT=16, new_game, no moves -> game_over rises 17 cycles after WAIT_MOVE entry, result 10; a move accepted on the 16th cycle instead -> move_ack and no forfeit.
REQ-032 Force error=1 during EVAL -> result 00, fault 1. new_game mid-game with move_valid high -> boards cleared, no ack or rej, WAIT_MOVE. rst_n=0 in OVER -> all REQ-026 values.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: accepts alternating X/O moves, checks legality,
// consults an external line evaluator after each accepted move, and forfeits idle players.
module ttt_game_ctrl #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  input  logic       win_x,
  input  logic       win_o,
  input  logic       full,
  input  logic       error,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  output logic       turn,
  output logic [3:0] move_count,
  output logic       move_ack,
  output logic       move_rej,
  output logic       game_over,
  output logic [1:0] result,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, WAIT_MOVE, EVAL, OVER} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  state_t      state_q, state_d;
  logic [8:0]  x_board_q, x_board_d, o_board_q, o_board_d;
  logic        turn_q, turn_d;
  logic [3:0]  move_count_q, move_count_d;
  logic [16:0] timer_q, timer_d;
  logic        move_ack_q, move_ack_d, move_rej_q, move_rej_d;
  logic [1:0]  result_q, result_d;
  logic        fault_q, fault_d;

  logic [15:0] cell_oh;
  logic        cell_legal, hs;

  // Cells 9..15 shift into the upper bits, which marks them illegal.
  assign cell_oh    = 16'(1) << move_cell;
  assign cell_legal = (cell_oh[15:9] == 7'd0) && ((cell_oh[8:0] & (x_board_q | o_board_q)) == 9'd0);
  assign hs         = move_valid && (state_q == WAIT_MOVE);

  always_comb begin
    state_d      = state_q;
    x_board_d    = x_board_q;
    o_board_d    = o_board_q;
    turn_d       = turn_q;
    move_count_d = move_count_q;
    timer_d      = timer_q;
    move_ack_d   = 1'b0;
    move_rej_d   = 1'b0;
    result_d     = result_q;
    fault_d      = fault_q;

    if (new_game) begin
      state_d      = WAIT_MOVE;
      x_board_d    = 9'd0;
      o_board_d    = 9'd0;
      turn_d       = 1'b0;
      move_count_d = 4'd0;
      timer_d      = 17'd0;
      result_d     = 2'b00;
      fault_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_MOVE: begin
          if (hs && cell_legal) begin
            if (turn_q) o_board_d = o_board_q | cell_oh[8:0];
            else        x_board_d = x_board_q | cell_oh[8:0];
            if (move_count_q != 4'd9) move_count_d = move_count_q + 4'd1;
            move_ack_d = 1'b1;
            state_d    = EVAL;
          end else begin
            move_rej_d = hs;
            // Expiry forfeits to the opponent of the player on move.
            if (timer_q >= TO_LIM) begin
              state_d  = OVER;
              result_d = turn_q ? 2'b01 : 2'b10;
            end else begin
              timer_d = timer_q + 17'd1;
            end
          end
        end
        EVAL: begin
          if (error) begin
            state_d  = OVER;
            result_d = 2'b00;
            fault_d  = 1'b1;
          end else if (win_x) begin
            state_d  = OVER;
            result_d = 2'b01;
          end else if (win_o) begin
            state_d  = OVER;
            result_d = 2'b10;
          end else if (full) begin
            state_d  = OVER;
            result_d = 2'b11;
          end else begin
            turn_d  = ~turn_q;
            timer_d = 17'd0;
            state_d = WAIT_MOVE;
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_board_q    <= 9'd0;
      o_board_q    <= 9'd0;
      turn_q       <= 1'b0;
      move_count_q <= 4'd0;
      timer_q      <= 17'd0;
      move_ack_q   <= 1'b0;
      move_rej_q   <= 1'b0;
      result_q     <= 2'b00;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_board_q    <= x_board_d;
      o_board_q    <= o_board_d;
      turn_q       <= turn_d;
      move_count_q <= move_count_d;
      timer_q      <= timer_d;
      move_ack_q   <= move_ack_d;
      move_rej_q   <= move_rej_d;
      result_q     <= result_d;
      fault_q      <= fault_d;
    end
  end

  assign move_ready = (state_q == WAIT_MOVE);
  assign game_over  = (state_q == OVER);
  assign x_board    = x_board_q;
  assign o_board    = o_board_q;
  assign turn       = turn_q;
  assign move_count = move_count_q;
  assign move_ack   = move_ack_q;
  assign move_rej   = move_rej_q;
  assign result     = result_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a behavioural line evaluator.
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, new_game, move_valid;
  logic [3:0] move_cell;
  logic       move_ready, win_x, win_o, full, error;
  logic [8:0] x_board, o_board;
  logic       turn, move_ack, move_rej, game_over, fault;
  logic [3:0] move_count;
  logic [1:0] result;
  logic       force_err;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
    .move_cell(move_cell), .move_ready(move_ready), .win_x(win_x), .win_o(win_o),
    .full(full), .error(error), .x_board(x_board), .o_board(o_board), .turn(turn),
    .move_count(move_count), .move_ack(move_ack), .move_rej(move_rej),
    .game_over(game_over), .result(result), .fault(fault)
  );

  function automatic logic has_line(input logic [8:0] b);
    return (&{b[0], b[1], b[2]}) || (&{b[3], b[4], b[5]}) || (&{b[6], b[7], b[8]}) ||
           (&{b[0], b[3], b[6]}) || (&{b[1], b[4], b[7]}) || (&{b[2], b[5], b[8]}) ||
           (&{b[0], b[4], b[8]}) || (&{b[2], b[4], b[6]});
  endfunction

  assign win_x = has_line(x_board);
  assign win_o = has_line(o_board);
  assign full  = &(x_board | o_board);
  assign error = force_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in WAIT_MOVE; returns at a negedge
  // after EVAL (accept) or right after the reject pulse.
  task automatic mv(input logic [3:0] c, input logic exp_ack, input string tag);
    move_valid = 1'b1;
    move_cell  = c;
    @(negedge clk);
    move_valid = 1'b0;
    chk({tag, "_ack"}, move_ack, exp_ack);
    chk({tag, "_rej"}, move_rej, !exp_ack);
    if (exp_ack) begin
      chk({tag, "_eval"}, game_over, 0);
      @(negedge clk);
    end
  endtask

  task automatic start_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd0; force_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state_ready", move_ready, 0);
    chk("rst_x", x_board, 0);
    chk("rst_o", o_board, 0);
    chk("rst_cnt", move_count, 0);
    chk("rst_ack", move_ack, 0);
    chk("rst_over", game_over, 0);
    rst_n = 1'b1; new_game = 1'b0; move_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", move_ready, 0);
    start_game();
    chk("wait_ready", move_ready, 1);

    // X wins on the top row
    mv(0, 1, "g1_x0"); mv(3, 1, "g1_o3"); mv(1, 1, "g1_x1"); mv(4, 1, "g1_o4");
    chk("g1_turn", turn, 0);
    mv(2, 1, "g1_x2");
    chk("g1_over", game_over, 1);
    chk("g1_res", result, 2'b01);
    chk("g1_x", x_board, 9'h007);
    chk("g1_o", o_board, 9'h018);
    chk("g1_cnt", move_count, 5);
    chk("g1_ready", move_ready, 0);
    move_valid = 1'b1; move_cell = 4'd8;
    repeat (3) @(negedge clk);
    move_valid = 1'b0;
    chk("over_noack", move_ack, 0);
    chk("over_hold_x", x_board, 9'h007);
    chk("over_hold", game_over, 1);

    // rejects: occupied cell and out-of-range cell
    start_game();
    mv(4, 1, "g2_x4");
    mv(4, 0, "g2_o4_busy");
    mv(12, 0, "g2_o12_bad");
    chk("g2_o", o_board, 0);
    chk("g2_turn", turn, 1);
    chk("g2_x", x_board, 9'h010);
    mv(0, 1, "g2_o0");
    chk("g2_o_after", o_board, 9'h001);

    // draw
    start_game();
    mv(4, 1, "g3_1"); mv(0, 1, "g3_2"); mv(2, 1, "g3_3"); mv(6, 1, "g3_4"); mv(3, 1, "g3_5");
    mv(5, 1, "g3_6"); mv(8, 1, "g3_7"); mv(1, 1, "g3_8"); mv(7, 1, "g3_9");
    chk("g3_over", game_over, 1);
    chk("g3_res", result, 2'b11);
    chk("g3_cnt", move_count, 9);

    // X forfeits after the timeout window
    start_game();
    repeat (16) @(negedge clk);
    chk("to_not_yet", game_over, 0);
    chk("to_ready", move_ready, 1);
    @(negedge clk);
    chk("to_over", game_over, 1);
    chk("to_res", result, 2'b10);

    // move on the 16th cycle wins over the forfeit; then O times out
    start_game();
    repeat (15) @(negedge clk);
    mv(5, 1, "late_x5");
    chk("late_no_forfeit", game_over, 0);
    chk("late_turn", turn, 1);
    repeat (16) @(negedge clk);
    chk("to_o_not_yet", game_over, 0);
    @(negedge clk);
    chk("to_o_over", game_over, 1);
    chk("to_o_res", result, 2'b01);

    // evaluator error
    start_game();
    chk("restart_res", result, 0);
    force_err = 1'b1;
    mv(0, 1, "err_x0");
    force_err = 1'b0;
    chk("err_over", game_over, 1);
    chk("err_res", result, 2'b00);
    chk("err_fault", fault, 1);

    // new_game mid-game drops the concurrent move
    start_game();
    chk("ng_fault_clr", fault, 0);
    mv(0, 1, "ng_x0");
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd3;
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0;
    chk("ng_ack", move_ack, 0);
    chk("ng_rej", move_rej, 0);
    chk("ng_x", x_board, 0);
    chk("ng_o", o_board, 0);
    chk("ng_turn", turn, 0);
    chk("ng_cnt", move_count, 0);
    chk("ng_ready", move_ready, 1);

    // reset in OVER overrides new_game and moves
    mv(0, 1, "r_x0"); mv(3, 1, "r_o3"); mv(1, 1, "r_x1"); mv(4, 1, "r_o4"); mv(2, 1, "r_x2");
    chk("r_over", game_over, 1);
    rst_n = 1'b0; new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd5;
    @(negedge clk);
    chk("r2_ready", move_ready, 0);
    chk("r2_over", game_over, 0);
    chk("r2_x", x_board, 0);
    chk("r2_o", o_board, 0);
    chk("r2_turn", turn, 0);
    chk("r2_cnt", move_count, 0);
    chk("r2_ack", move_ack, 0);
    chk("r2_rej", move_rej, 0);
    chk("r2_res", result, 0);
    chk("r2_fault", fault, 0);
    rst_n = 1'b1; new_game = 1'b0; move_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
